// File: rtl/m_shlseq_if.sv
// Handshake and datapath bundle between the shift sequencer and its ALU/requester.
interface m_shlseq_if #(
  parameter int unsigned ALUWIDTH = 8,
  parameter int unsigned SHW      = 5
);
  logic                start;
  logic [1:0]          op;
  logic [SHW-1:0]      shamt;
  logic                abort;
  logic [ALUWIDTH-1:0] B;
  logic [ALUWIDTH-1:0] opq;
  logic                dones;
  logic                sa06;
  logic                sa05;
  logic                sa04;
  logic                alu_carryin;
  logic                busy;
  logic                done;

  // Sequencer side
  modport slave (
    input  start, op, shamt, abort, B,
    output opq, dones, sa06, sa05, sa04, alu_carryin, busy, done
  );

  // Requester / ALU side
  modport master (
    output start, op, shamt, abort, B,
    input  opq, dones, sa06, sa05, sa04, alu_carryin, busy, done
  );
endinterface

// File: rtl/m_shlseq.sv
// Multi-cycle shift sequencer: drives m_alu with PASSD/SHLQ micro-ops and
// captures B back into the shift-operand register each cycle.
module m_shlseq #(
  parameter int unsigned ALUWIDTH = 8,
  parameter int unsigned SHW      = 5
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  m_shlseq_if.slave   bus
);

  localparam int unsigned OPW = 2;
  localparam logic [OPW-1:0] OP_SHL  = 2'b00;
  localparam logic [OPW-1:0] OP_ROL  = 2'b01;
  localparam logic [OPW-1:0] OP_SHL1 = 2'b10;
  localparam logic [OPW-1:0] OP_LOAD = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              state_q;
  logic [ALUWIDTH-1:0] opq_q;
  logic [SHW-1:0]      cnt_q;
  logic [OPW-1:0]      opr_q;
  logic                accept;

  // A new request is taken only from IDLE/DONE, and abort always wins.
  assign accept = bus.start & ~bus.abort;

  // Sequencer state, shift register, step counter and latched opcode.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_q <= S_IDLE;
      opq_q   <= '0;
      cnt_q   <= '0;
      opr_q   <= OP_SHL;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (accept) begin
            state_q <= S_LOAD;
            opr_q   <= bus.op;
            cnt_q   <= bus.shamt;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_LOAD: begin
          if (bus.abort) begin
            state_q <= S_IDLE;
          end else begin
            opq_q <= bus.B;
            if ((cnt_q == '0) || (opr_q == OP_LOAD)) begin
              state_q <= S_DONE;
            end else begin
              state_q <= S_SHIFT;
            end
          end
        end
        S_SHIFT: begin
          if (bus.abort) begin
            state_q <= S_IDLE;
          end else begin
            opq_q <= bus.B;
            cnt_q <= cnt_q - SHW'(1);
            if (cnt_q == SHW'(1)) begin
              state_q <= S_DONE;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Micro-op and status decode from the registered state and opcode only.
  always_comb begin
    bus.sa06        = 1'b0;
    bus.sa05        = 1'b0;
    bus.sa04        = 1'b1;
    bus.dones       = 1'b0;
    bus.alu_carryin = 1'b0;
    bus.busy        = 1'b0;
    bus.done        = 1'b0;
    case (state_q)
      S_LOAD: begin
        bus.busy = 1'b1;
      end
      S_SHIFT: begin
        bus.sa06  = 1'b1;
        bus.busy  = 1'b1;
        bus.dones = 1'b1;
        case (opr_q)
          OP_ROL:  bus.alu_carryin = opq_q[ALUWIDTH-1];
          OP_SHL1: bus.alu_carryin = 1'b1;
          default: bus.alu_carryin = 1'b0;
        endcase
      end
      S_DONE: begin
        bus.done = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.opq = opq_q;

endmodule

// File: tb/tb_m_shlseq.sv
// Directed and randomized checks of m_shlseq against a behavioral ALU and
// closed-form shift/rotate reference.
module tb_m_shlseq;

  localparam int unsigned W   = 8;
  localparam int unsigned SHW = 5;

  logic         clk;
  logic         rst;
  logic [W-1:0] operand;
  logic [W-1:0] di;

  int n_chk;
  int n_err;

  m_shlseq_if #(.ALUWIDTH(W), .SHW(SHW)) bus ();

  m_shlseq #(.ALUWIDTH(W), .SHW(SHW)) dut (
    .CLK_I (clk),
    .RST_I (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioral m_alu subset: PASSD and SHLQ with ADR_O = QQ = opq.
  always_comb begin
    di = bus.dones ? 8'hFF : operand;
    case ({bus.sa06, bus.sa05, bus.sa04})
      3'b001:  bus.B = di;
      3'b101:  bus.B = bus.opq + bus.opq + W'(bus.alu_carryin);
      default: bus.B = 8'h00;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_model(input logic [1:0] o, input logic [4:0] s,
                                             input logic [W-1:0] d);
    logic [2*W-1:0] dbl;
    logic [W-1:0]   r;
    case (o)
      2'b00: r = d << s;
      2'b01: begin
        dbl = {d, d} << (s % W);
        r   = dbl[2*W-1:W];
      end
      2'b10: r = ~((~d) << s);
      default: r = d;
    endcase
    return r;
  endfunction

  function automatic int exp_lat(input logic [1:0] o, input logic [4:0] s);
    return ((o == 2'b11) || (s == 5'd0)) ? 2 : int'(s) + 2;
  endfunction

  // One request; counts cycles after the accepting edge until done.
  task automatic do_op(input logic [1:0] o, input logic [4:0] s, input logic [W-1:0] d,
                       input bit poke, output int lat, output int bcnt, output logic [W-1:0] res);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = o;
    bus.shamt = s;
    operand   = d;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    lat  = -1;
    bcnt = 0;
    res  = '0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (bus.busy) bcnt++;
      if (poke && k == 1) begin
        bus.start = 1'b1;
        bus.op    = ~o;
        bus.shamt = s + 5'd3;
      end
      if (poke && k == 2) bus.start = 1'b0;
      if (bus.done) begin
        lat = k;
        res = bus.opq;
        break;
      end
    end
    bus.start = 1'b0;
  endtask

  typedef struct {
    logic [1:0]   op;
    logic [4:0]   sh;
    logic [W-1:0] d;
    logic [W-1:0] exp;
    int           lat;
  } vec_t;

  vec_t vt[7];

  initial begin
    int           lat;
    int           bc;
    int           pulses;
    logic [W-1:0] res;
    logic [1:0]   ro;
    logic [4:0]   rs;
    logic [W-1:0] rd;

    n_chk = 0;
    n_err = 0;
    vt[0] = '{2'b00, 5'd3,  8'h35, 8'hA8, 5};
    vt[1] = '{2'b01, 5'd1,  8'h81, 8'h03, 3};
    vt[2] = '{2'b01, 5'd9,  8'h81, 8'h03, 11};
    vt[3] = '{2'b10, 5'd4,  8'h00, 8'h0F, 6};
    vt[4] = '{2'b00, 5'd0,  8'hC3, 8'hC3, 2};
    vt[5] = '{2'b00, 5'd31, 8'hFF, 8'h00, 33};
    vt[6] = '{2'b11, 5'd7,  8'h5A, 8'h5A, 2};

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.shamt = '0;
    bus.abort = 1'b0;
    operand   = 8'h77;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_opq",   32'(bus.opq), 32'h00);
    chk("rst_busy",  32'(bus.busy), 32'h0);
    chk("rst_done",  32'(bus.done), 32'h0);
    chk("rst_dones", 32'(bus.dones), 32'h0);
    chk("rst_sa",    32'({bus.sa06, bus.sa05, bus.sa04}), 32'h1);
    chk("rst_cin",   32'(bus.alu_carryin), 32'h0);
    rst = 1'b0;

    // Directed table
    foreach (vt[i]) begin
      do_op(vt[i].op, vt[i].sh, vt[i].d, 1'b0, lat, bc, res);
      chk($sformatf("vec%0d_result", i), 32'(res), 32'(vt[i].exp));
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vt[i].lat));
      chk($sformatf("vec%0d_busy", i), 32'(bc), 32'(vt[i].lat - 1));
    end

    // Back-to-back with start held high across DONE
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b00; bus.shamt = 5'd2; operand = 8'h35;
    @(posedge clk); #1;
    bus.shamt = 5'd1;
    @(negedge clk);
    chk("b2b_load1_busy", 32'(bus.busy), 32'h1);
    @(negedge clk);
    operand = 8'h01;
    chk("b2b_shift_sa", 32'({bus.sa06, bus.sa05, bus.sa04}), 32'h5);
    @(negedge clk);
    @(negedge clk);
    chk("b2b_done1", 32'(bus.done), 32'h1);
    chk("b2b_res1", 32'(bus.opq), 32'hD4);
    @(negedge clk);
    bus.start = 1'b0;
    chk("b2b_load2_busy", 32'(bus.busy), 32'h1);
    chk("b2b_load2_done", 32'(bus.done), 32'h0);
    @(negedge clk);
    @(negedge clk);
    chk("b2b_done2", 32'(bus.done), 32'h1);
    chk("b2b_res2", 32'(bus.opq), 32'h02);

    // Abort in second SHIFT
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b00; bus.shamt = 5'd5; operand = 8'h11;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort_shift_dones", 32'(bus.dones), 32'h1);
    @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    chk("abort_busy", 32'(bus.busy), 32'h0);
    chk("abort_sa", 32'({bus.sa06, bus.sa05, bus.sa04}), 32'h1);
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus.done || bus.busy) pulses++;
    end
    chk("abort_no_done", 32'(pulses), 32'h0);

    // start and abort together in IDLE
    @(negedge clk);
    bus.start = 1'b1; bus.abort = 1'b1; bus.op = 2'b00; bus.shamt = 5'd2;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.abort = 1'b0;
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (bus.done || bus.busy) pulses++;
    end
    chk("start_abort_idle", 32'(pulses), 32'h0);

    // Reset mid-SHIFT
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b01; bus.shamt = 5'd6; operand = 8'hA5;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_opq", 32'(bus.opq), 32'h00);
    chk("midrst_busy", 32'(bus.busy), 32'h0);
    chk("midrst_sa", 32'({bus.sa06, bus.sa05, bus.sa04}), 32'h1);
    chk("midrst_done", 32'(bus.done), 32'h0);

    // Random triples with an ignored start poked during LOAD
    for (int n = 0; n < 1000; n++) begin
      ro = 2'($urandom_range(0, 3));
      rs = 5'($urandom_range(0, 31));
      rd = 8'($urandom);
      do_op(ro, rs, rd, 1'b1, lat, bc, res);
      chk($sformatf("rnd%0d_op%0d_sh%0d_d%0h_res", n, ro, rs, rd), 32'(res), 32'(ref_model(ro, rs, rd)));
      chk($sformatf("rnd%0d_lat", n), 32'(lat), 32'(exp_lat(ro, rs)));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
